fixed_divide: RTL

//  Inverse of add_multiply: recovers the Q2.7 factor S = Y / C from add_multiply's Q4.6

---
 rtl/fixed_divide_pkg.sv | 28 ++
 rtl/fx_saturate.sv | 36 +++
 rtl/fixed_divide.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fixed_divide_pkg.sv
// Q-format widths, saturation codes, FSM states and the latched operand context for fixed_divide.
// No logic; shared constants and types only.
package fixed_divide_pkg;

   localparam int FX_W     = 9;
   localparam int FX_FRAC  = 7;
   localparam int FX_YW    = 10;
   localparam int FX_YFRAC = 6;

   localparam logic [FX_W-1:0] FX_SAT_MAX = 9'h0FF;
   localparam logic [FX_W-1:0] FX_SAT_MIN = 9'h100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SAT  = 2'd2
   } state_t;

   // Operand facts captured at acceptance; the magnitude loop never sees signs.
   typedef struct packed {
      logic q_neg;
      logic y_neg;
      logic y_nz;
      logic y_big;
      logic c_zero;
   } op_ctx_t;

endpackage

// File: rtl/fx_saturate.sv
// Applies a sign to an unsigned magnitude and clamps it into a W-bit two's-complement result.
// Latency: combinational.
// Backpressure: none.
module fx_saturate #(
   parameter int MW = 17,
   parameter int W  = 9
) (
   input  logic [MW-1:0] mag,
   input  logic          neg,
   output logic [W-1:0]  s,
   output logic          ovf
);

   localparam logic [MW-1:0] POS_LIM = MW'((1 << (W-1)) - 1);
   localparam logic [MW-1:0] NEG_LIM = MW'(1 << (W-1));
   localparam logic [W-1:0]  SAT_POS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]  SAT_NEG = {1'b1, {(W-1){1'b0}}};

   always_comb begin
      s   = mag[W-1:0];
      ovf = 1'b0;
      if (neg) begin
         // Exactly -2^(W-1) is representable, so only strictly larger magnitudes clamp.
         if (mag > NEG_LIM) begin
            s   = SAT_NEG;
            ovf = 1'b1;
         end else begin
            s = ~mag[W-1:0] + 1'b1;
         end
      end else if (mag > POS_LIM) begin
         s   = SAT_POS;
         ovf = 1'b1;
      end
   end

endmodule

// File: rtl/fixed_divide.sv
// Restoring divider recovering Q2.7 S = Y / C from a Q4.6 product Y and Q2.7 multiplier C.
// Latency: done 19 ce-high clks after the start cycle (2 when C is zero).
// Backpressure: start ignored while busy; ce low stalls everything except the done pulse clear.
module fixed_divide
   import fixed_divide_pkg::*;
#(
   parameter int W     = FX_W,
   parameter int FRAC  = FX_FRAC,
   parameter int YW    = FX_YW,
   parameter int YFRAC = FX_YFRAC
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   input  logic          start,
   input  logic [YW-1:0] Y,
   input  logic [W-1:0]  C,
   output logic [W-1:0]  S,
   output logic          busy,
   output logic          done,
   output logic          ovf,
   output logic          dz
);

   localparam int SHIFT = 2*FRAC - YFRAC;
   localparam int ITER  = YW - 1 + SHIFT;
   localparam int CW    = $clog2(ITER);

   state_t          state, state_nxt;
   op_ctx_t         ctx;
   logic [ITER-1:0] dq;
   logic [W-1:0]    rem;
   logic [W-1:0]    dvs;
   logic [CW-1:0]   cnt;

   logic [YW-1:0]   y_mag;
   logic [W-1:0]    c_mag;
   logic [W:0]      rem_sh;
   logic [W-1:0]    rem_diff;
   logic            q_bit;
   logic [ITER-1:0] sat_mag;
   logic            sat_neg;
   logic [W-1:0]    sat_s;
   logic            sat_ovf;

   always_comb begin
      y_mag    = Y[YW-1] ? (~Y + 1'b1) : Y;
      c_mag    = C[W-1]  ? (~C + 1'b1) : C;
      rem_sh   = {rem, dq[ITER-1]};
      rem_diff = rem_sh[W-1:0] - dvs;
      q_bit    = (rem_sh >= {1'b0, dvs});
      // |Y| = 2^(YW-1) does not fit the dividend register but always saturates anyway.
      if (ctx.c_zero) begin
         sat_mag = {ITER{ctx.y_nz}};
         sat_neg = ctx.y_neg;
      end else begin
         sat_mag = ctx.y_big ? {ITER{1'b1}} : dq;
         sat_neg = ctx.q_neg;
      end
   end

   fx_saturate #(
      .MW (ITER),
      .W  (W)
   ) u_sat (
      .mag (sat_mag),
      .neg (sat_neg),
      .s   (sat_s),
      .ovf (sat_ovf)
   );

   always_comb begin
      state_nxt = state;
      if (ce) begin
         case (state)
            IDLE:    if (start) state_nxt = (C == '0) ? SAT : CALC;
            CALC:    if (cnt == '0) state_nxt = SAT;
            SAT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         S     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         ovf   <= 1'b0;
         dz    <= 1'b0;
         ctx   <= '0;
         dq    <= '0;
         rem   <= '0;
         dvs   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         if (ce) begin
            case (state)
               IDLE: begin
                  if (start) begin
                     busy       <= 1'b1;
                     dq         <= {y_mag[YW-2:0], {SHIFT{1'b0}}};
                     rem        <= '0;
                     dvs        <= c_mag;
                     cnt        <= CW'(ITER - 1);
                     ctx.q_neg  <= Y[YW-1] ^ C[W-1];
                     ctx.y_neg  <= Y[YW-1];
                     ctx.y_nz   <= (Y != '0);
                     ctx.y_big  <= y_mag[YW-1];
                     ctx.c_zero <= (C == '0);
                  end
               end
               CALC: begin
                  rem <= q_bit ? rem_diff : rem_sh[W-1:0];
                  dq  <= {dq[ITER-2:0], q_bit};
                  cnt <= cnt - 1'b1;
               end
               SAT: begin
                  S    <= sat_s;
                  ovf  <= sat_ovf & ~ctx.c_zero;
                  dz   <= ctx.c_zero;
                  done <= 1'b1;
                  busy <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
